// File: rtl/online_digit_to_parallel.sv
// rtl/online_digit_to_parallel.sv - radix-4 on-the-fly converter from MSDF signed digits to two's complement
module online_digit_to_parallel #(
    parameter int N_DIGITS     = 8,
    parameter int ONLINE_DELAY = 2,
    parameter int RESULT_WIDTH = 2*N_DIGITS+2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              digit,
    input  logic                    digit_valid,
    output logic                    digit_ready,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    digit_err
);

    localparam int CW = $clog2(N_DIGITS + ONLINE_DELAY + 1);

    typedef enum logic [1:0] {SKIP, CONV, DONE} state_t;
    localparam state_t START_STATE = (ONLINE_DELAY == 0) ? CONV : SKIP;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RESULT_WIDTH-1:0] q_q, q_d;
    logic [RESULT_WIDTH-1:0] qm_q, qm_d;
    logic                    err_q, err_d;

    logic       accept;
    logic       legal, dpos, dneg;
    logic [1:0] q_lo, qm_lo;

    assign digit_ready  = !rst && (state_q != DONE);
    assign accept       = digit_valid && digit_ready;
    assign result       = q_q;
    assign result_valid = (state_q == DONE);
    assign digit_err    = err_q;

    // Appended low bits: Q takes d (or 4+d), QM takes d-1 (or 3+d); illegal codes act as 0.
    always_comb begin
        legal = digit inside {3'b000, 3'b001, 3'b010, 3'b111, 3'b110};
        dpos  = legal && (digit == 3'b001 || digit == 3'b010);
        dneg  = legal && digit[2];
        q_lo  = (dpos || dneg) ? digit[1:0] : 2'b00;
        if (dpos)
            qm_lo = {1'b0, digit[1]};
        else if (dneg)
            qm_lo = {digit[0], ~digit[0]};
        else
            qm_lo = 2'b11;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        qm_d    = qm_q;
        err_d   = err_q;
        case (state_q)
            SKIP: begin
                if (accept) begin
                    err_d = err_q | ~legal;
                    if (int'(cnt_q) == ONLINE_DELAY - 1) begin
                        state_d = CONV;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CONV: begin
                if (accept) begin
                    err_d = err_q | ~legal;
                    q_d   = ((dneg ? qm_q : q_q) << 2) | {{(RESULT_WIDTH-2){1'b0}}, q_lo};
                    qm_d  = ((dpos ? q_q : qm_q) << 2) | {{(RESULT_WIDTH-2){1'b0}}, qm_lo};
                    cnt_d = cnt_q + CW'(1);
                    if (int'(cnt_q) == N_DIGITS - 1)
                        state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = START_STATE;
                    cnt_d   = '0;
                    q_d     = '0;
                    qm_d    = '1;
                    err_d   = 1'b0;
                end
            end
            default: state_d = START_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= START_STATE;
            cnt_q   <= '0;
            q_q     <= '0;
            qm_q    <= '1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            err_q   <= err_d;
        end
    end

endmodule
